// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one sequential multiplier among N_REQ requesters
//
// Parameters: N_REQ (requesters, 2..8), WIDTH (operand bits),
//             TIMEOUT (WAIT watchdog cycles, only with MUL_ARB_TIMEOUT_EN).
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req                   per-requester multiply request
//   req_a, req_b          packed operands, slice i belongs to requester i
//   gnt                   one-hot grant, held for the whole transaction
//   rsp_valid             one-hot one-cycle result strobe
//   rsp_data, rsp_err     full product and timeout flag, qualified by rsp_valid
//   mul_start             one-cycle start pulse to the multiplier
//   mul_a, mul_b          latched operands, stable until mul_done
//   mul_done, mul_result  multiplier completion strobe and product
// Optional feature: define MUL_ARB_TIMEOUT_EN to add an 8-bit WAIT watchdog.
module mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
`ifdef MUL_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 40
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_result
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   win;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   k;
    logic            found;

    // Search starts just past the previous winner so a requester that keeps
    // req high cannot starve the others.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        k     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = IW'((int'(last_winner) + i) % N_REQ);
            if (!found && req[k]) begin
                found = 1'b1;
                sel   = k;
            end
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= IW'(N_REQ - 1);
            win         <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            rsp_err     <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        win       <= sel;
                        gnt       <= N_REQ'(1) << sel;
                        mul_a     <= req_a[sel*WIDTH +: WIDTH];
                        mul_b     <= req_b[sel*WIDTH +: WIDTH];
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    state     <= WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                WAIT: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_valid <= gnt;
                        state     <= RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= gnt;
                        state     <= RESP;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid   <= '0;
                    gnt         <= '0;
                    last_winner <= win;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter
module tb_mul_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_data;
    logic           rsp_err;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done = 1'b0;
    logic [2*W-1:0] mul_result = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit bad;
    int n;

    always #5 clk = ~clk;

    mul_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called in the IDLE cycle in which req is already driven (cycle 0).
    // Plays the multiplier: a stray done during ISSUE, then the real done
    // dly cycles after mul_start. With post set, req drops and the
    // winner's operand A is rewritten right after the grant.
    task automatic txn(input int idx, input int dly, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic [2*W-1:0] ed, input bit post);
        logic [N-1:0] eg;
        logic [W-1:0] a, b;
        bit hb;
        eg = N'(1) << idx;
        tick;
        check("start", mul_start, 1);
        check("gnt", gnt, eg);
        check("mul_a", mul_a, ea);
        check("mul_b", mul_b, eb);
        a = mul_a;
        b = mul_b;
        if (post) begin
            req = '0;
            req_a[idx*W +: W] = 9;
        end
        mul_done = 1'b1;
        mul_result = 64'hdead;
        tick;
        mul_done = 1'b0;
        check("start_off", mul_start, 0);
        hb = (rsp_valid != 0);
        repeat (dly - 1) begin
            tick;
            if (rsp_valid != 0 || mul_a != a || mul_b != b || gnt != eg || mul_start != 0) hb = 1'b1;
        end
        check("hold", hb, 0);
        mul_done = 1'b1;
        mul_result = 64'(a) * 64'(b);
        tick;
        mul_done = 1'b0;
        mul_result = '0;
        check("rsp_valid", rsp_valid, eg);
        check("rsp_data", rsp_data, ed);
        check("rsp_err", rsp_err, 0);
        check("gnt_resp", gnt, eg);
        tick;
        check("rsp_off", rsp_valid, 0);
        check("gnt_off", gnt, 0);
    endtask

    initial begin
        repeat (2) tick;
        rst = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);

        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 2);
            req_b[i*W +: W] = W'(i + 10);
        end
        req = 4'b1111;
        txn(0, 3, 2, 10, 20, 0);
        txn(1, 3, 3, 11, 33, 0);
        txn(2, 3, 4, 12, 48, 0);
        txn(3, 3, 5, 13, 65, 0);
        txn(0, 3, 2, 10, 20, 0);
        req = '0;

        req_a[0 +: W] = 7;
        req_b[0 +: W] = 6;
        req = 4'b0001;
        txn(0, 33, 7, 6, 42, 1);

        req_a[2*W +: W] = 32'hFFFF_FFFF;
        req_b[2*W +: W] = 32'hFFFF_FFFF;
        req = 4'b0100;
        txn(2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);

        req_a[W +: W] = 4;
        req_b[W +: W] = 4;
        req = 4'b0010;
        tick;
        check("wr_start", mul_start, 1);
        check("wr_gnt", gnt, 4'b0010);
        req = '0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("wr_gnt_clr", gnt, 0);
        check("wr_rsp_data", rsp_data, 0);
        check("wr_mul_a", mul_a, 0);
        check("wr_start_clr", mul_start, 0);
        mul_done = 1'b1;
        mul_result = 64'd16;
        tick;
        mul_done = 1'b0;
        mul_result = '0;
        bad = 1'b0;
        repeat (3) begin
            if (rsp_valid != 0 || gnt != 0 || mul_start != 0) bad = 1'b1;
            tick;
        end
        check("wr_quiet", bad, 0);

        req_a[0 +: W] = 3;
        req_b[0 +: W] = 5;
        req = 4'b0001;
        txn(0, 5, 3, 5, 15, 1);

`ifdef MUL_ARB_TIMEOUT_EN
        req_a[3*W +: W] = 5;
        req_b[3*W +: W] = 5;
        req = 4'b1000;
        tick;
        check("tmo_start", mul_start, 1);
        req = '0;
        n = 0;
        while (rsp_valid == 0 && n < 100) begin
            tick;
            n++;
        end
        check("tmo_latency", n, 41);
        check("tmo_rsp_valid", rsp_valid, 4'b1000);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_data", rsp_data, 0);
        tick;
        check("tmo_rsp_off", rsp_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
